sponge_squeeze: RTL and testbench

Parametrised squeeze-phase controller for the sponge construction. It takes the post-absorb state (rate r, capacity c) and a requested output length in bits. It streams the output as rate-sized chunks on a valid/ready interface and runs the external permutation G between chunks. The final chunk is masked to the residual length. It sits between the absorb controller and the hash/XOF output port, and shares the G permutation through a start/done handshake.

---
 rtl/sponge_pkg.sv | 21 ++
 rtl/squeeze_mask.sv | 20 ++
 rtl/sponge_squeeze.sv | 136 +++++++++++++
 tb/tb_sponge_squeeze.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sponge_pkg.sv
// Shared types and helpers for the sponge absorb/squeeze controllers.
package sponge_pkg;

  localparam int RWIDTH_D      = 32;
  localparam int CWIDTH_D      = 320;
  localparam int ROUND_COUNT_D = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EMIT    = 3'd1,
    PERMUTE = 3'd2,
    WAIT    = 3'd3,
    DONE    = 3'd4
  } squeeze_state_t;

  // Smaller of two lengths; used to size the current output chunk.
  function automatic int unsigned min_len(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/squeeze_mask.sv
// Keeps the low 'bits' bits of data and zeroes the rest.
// A bits value of W or more passes data through untouched.
module squeeze_mask #(
  parameter int W  = 32,
  parameter int BW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data,
  input  logic [BW-1:0] bits,
  output logic [W-1:0]  masked
);

  logic [W-1:0] keep;

  // Build the LSB keep-mask and apply it.
  always_comb begin
    keep   = ~({W{1'b1}} << bits);
    masked = data & keep;
  end

endmodule

// File: rtl/sponge_squeeze.sv
// Squeeze-phase controller: streams rate-sized chunks of the sponge state
// and runs the shared permutation G between chunks.
//
// state   | meaning
// IDLE    | waiting for start
// EMIT    | presenting a chunk, waiting for dout_ready
// PERMUTE | one-cycle perm_go to G
// WAIT    | G running, perm_r/perm_c held
// DONE    | one-cycle done pulse
module sponge_squeeze
  import sponge_pkg::*;
#(
  parameter int RWIDTH      = RWIDTH_D,
  parameter int CWIDTH      = CWIDTH_D,
  parameter int LEN_WIDTH   = 20,
  parameter int ROUND_COUNT = ROUND_COUNT_D,
  parameter int CNT_WIDTH   = $clog2(RWIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [RWIDTH-1:0]      r_in,
  input  logic [CWIDTH-1:0]      c_in,
  input  logic [LEN_WIDTH-1:0]   out_len,
  input  logic [ROUND_COUNT-1:0] rounds,
  output logic                   busy,
  output logic                   perm_go,
  output logic [RWIDTH-1:0]      perm_r,
  output logic [CWIDTH-1:0]      perm_c,
  output logic [ROUND_COUNT-1:0] perm_rounds,
  input  logic                   perm_done,
  input  logic [RWIDTH-1:0]      perm_r_in,
  input  logic [CWIDTH-1:0]      perm_c_in,
  output logic [RWIDTH-1:0]      dout,
  output logic [CNT_WIDTH-1:0]   dout_bits,
  output logic                   dout_valid,
  output logic                   dout_last,
  input  logic                   dout_ready,
  output logic                   done
);

  localparam logic [LEN_WIDTH-1:0] RW_LEN = LEN_WIDTH'(RWIDTH);

  squeeze_state_t         state;
  logic [RWIDTH-1:0]      r_reg;
  logic [CWIDTH-1:0]      c_reg;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [ROUND_COUNT-1:0] rounds_reg;

  logic                   is_last;
  logic [LEN_WIDTH-1:0]   chunk;
  logic [CNT_WIDTH-1:0]   chunk_bits;
  logic [RWIDTH-1:0]      masked_r;

  // Current chunk size; the compare is done at length width so RWIDTH never truncates.
  always_comb begin
    is_last    = (remaining <= RW_LEN);
    chunk      = LEN_WIDTH'(min_len(32'(remaining), 32'(RW_LEN)));
    chunk_bits = CNT_WIDTH'(chunk);
  end

  squeeze_mask #(
    .W  (RWIDTH),
    .BW (CNT_WIDTH)
  ) u_mask (
    .data   (r_reg),
    .bits   (chunk_bits),
    .masked (masked_r)
  );

  // Moore outputs decoded from the registered state.
  always_comb begin
    busy       = (state != IDLE);
    perm_go    = (state == PERMUTE);
    perm_r     = '0;
    perm_c     = '0;
    dout       = '0;
    dout_bits  = '0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    done       = (state == DONE);
    if (state == PERMUTE || state == WAIT) begin
      perm_r = r_reg;
      perm_c = c_reg;
    end
    if (state == EMIT) begin
      dout       = masked_r;
      dout_bits  = chunk_bits;
      dout_valid = 1'b1;
      dout_last  = is_last;
    end
  end

  assign perm_rounds = rounds_reg;

  // Sequencing and state/length registers; start, perm_done and dout_ready
  // only matter in IDLE, WAIT and EMIT respectively.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      r_reg      <= '0;
      c_reg      <= '0;
      remaining  <= '0;
      rounds_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            r_reg      <= r_in;
            c_reg      <= c_in;
            remaining  <= out_len;
            rounds_reg <= rounds;
            state      <= (out_len == '0) ? DONE : EMIT;
          end
        end
        EMIT: begin
          if (dout_ready) begin
            remaining <= remaining - chunk;
            state     <= is_last ? DONE : PERMUTE;
          end
        end
        PERMUTE: state <= WAIT;
        WAIT: begin
          if (perm_done) begin
            r_reg <= perm_r_in;
            c_reg <= perm_c_in;
            state <= EMIT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sponge_squeeze.sv
// Bench for sponge_squeeze: vector table, random runs, and hand sequences
// for backpressure, reset during WAIT and spurious inputs.
module tb_sponge_squeeze;

  typedef struct {
    logic [31:0]  r;
    logic [319:0] c;
    logic [19:0]  len;
    logic [9:0]   rounds;
    int           rmode;
    bit           spur;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  r_in = '0;
  logic [319:0] c_in = '0;
  logic [19:0]  out_len = '0;
  logic [9:0]   rounds = '0;
  logic         busy, perm_go, dout_valid, dout_last, done;
  logic [31:0]  perm_r, dout;
  logic [319:0] perm_c;
  logic [9:0]   perm_rounds;
  logic         perm_done = 1'b0;
  logic [31:0]  perm_r_in = '0;
  logic [319:0] perm_c_in = '0;
  logic [5:0]   dout_bits;
  logic         dout_ready = 1'b1;

  sponge_squeeze dut (
    .clk(clk), .reset(reset), .start(start), .r_in(r_in), .c_in(c_in),
    .out_len(out_len), .rounds(rounds), .busy(busy), .perm_go(perm_go),
    .perm_r(perm_r), .perm_c(perm_c), .perm_rounds(perm_rounds),
    .perm_done(perm_done), .perm_r_in(perm_r_in), .perm_c_in(perm_c_in),
    .dout(dout), .dout_bits(dout_bits), .dout_valid(dout_valid),
    .dout_last(dout_last), .dout_ready(dout_ready), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [351:0] act, input logic [351:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference permutation used by the G stand-in and by the model.
  function automatic logic [351:0] g_fn(input logic [31:0] r, input logic [319:0] c, input logic [9:0] rd);
    logic [31:0]  r2;
    logic [319:0] c2;
    r2 = (r * 32'h9E3779B1) ^ c[31:0] ^ {22'd0, rd};
    c2 = {c[287:0], ~r};
    return {c2, r2};
  endfunction

  // Expected stream, computed from the length/chunk rules.
  logic [31:0]  exp_dout[$];
  int           exp_bits[$];
  bit           exp_last[$];
  logic [31:0]  exp_pr[$];
  logic [319:0] exp_pc[$];
  logic [9:0]   exp_rounds;
  logic [31:0]  ovr_r[$];
  logic [31:0]  act_dout[$];
  int           act_bits[$];

  int beats, gos, dones, busy_cnt, valid_cnt;
  int start_cyc, first_valid_cyc, first_hs_cyc, last_hs_cyc, done_cyc, first_go_cyc;
  int ready_mode = 0;
  bit spur_en = 1'b0;
  bit stab_off = 1'b0;
  int g_lat_fixed = -1;

  task automatic model(input vec_t v);
    logic [31:0]  r;
    logic [319:0] c;
    int rem, ch, k;
    exp_dout.delete(); exp_bits.delete(); exp_last.delete();
    exp_pr.delete(); exp_pc.delete();
    exp_rounds = v.rounds;
    r = v.r; c = v.c; rem = int'(v.len); k = 0;
    while (rem > 0) begin
      ch = (rem < 32) ? rem : 32;
      exp_dout.push_back((ch == 32) ? r : (r & ((32'h1 << ch) - 32'h1)));
      exp_bits.push_back(ch);
      exp_last.push_back(rem <= 32);
      rem -= ch;
      if (rem > 0) begin
        exp_pr.push_back(r);
        exp_pc.push_back(c);
        {c, r} = g_fn(r, c, v.rounds);
        if (k < ovr_r.size()) begin
          r = ovr_r[k];
          k++;
        end
      end
    end
  endtask

  task automatic clear_counts();
    beats = 0; gos = 0; dones = 0; busy_cnt = 0; valid_cnt = 0;
    first_valid_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
    done_cyc = -1; first_go_cyc = -1;
    act_dout.delete(); act_bits.delete();
  endtask

  task automatic prep(input vec_t v);
    model(v);
    clear_counts();
    ready_mode = v.rmode;
    spur_en = v.spur;
  endtask

  // Output monitor: beats, hold during stall, done timing.
  bit          p_stall = 1'b0;
  logic [31:0] p_dout;
  logic [5:0]  p_bits;
  logic        p_last;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      p_stall = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (dout_valid) valid_cnt++;
      if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (p_stall)
        check("stall_hold", {dout_valid, dout_last, dout_bits, dout}, {1'b1, p_last, p_bits, p_dout});
      if (dout_valid && dout_ready) begin
        act_dout.push_back(dout);
        act_bits.push_back(int'(dout_bits));
        if (beats < exp_dout.size()) begin
          check("beat_dout", dout, exp_dout[beats]);
          check("beat_bits", dout_bits, exp_bits[beats]);
          check("beat_last", dout_last, exp_last[beats]);
        end else begin
          check("extra_beat", 1'b1, 1'b0);
        end
        beats++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
      end
      p_stall = dout_valid && !dout_ready;
      p_dout = dout; p_bits = dout_bits; p_last = dout_last;
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
    end
  end

  // G stand-in: answers each perm_go after a short latency, checks the hold.
  bit           g_pending = 1'b0;
  bit           g_fire = 1'b0;
  int           g_cnt = 0;
  logic [31:0]  g_cap_r;
  logic [319:0] g_cap_c;
  logic [9:0]   g_cap_rd;
  initial forever begin
    logic [31:0]  r2;
    logic [319:0] c2;
    @(negedge clk);
    if (g_fire) begin
      perm_done = 1'b0;
      g_fire = 1'b0;
    end
    if (g_pending) begin
      if (!stab_off) begin
        check("perm_go_pulse", perm_go, 1'b0);
        check("perm_r_hold", perm_r, g_cap_r);
        check("perm_c_hold", perm_c, g_cap_c);
      end
      if (g_cnt == 0) begin
        {c2, r2} = g_fn(g_cap_r, g_cap_c, g_cap_rd);
        if (ovr_r.size() > 0) r2 = ovr_r.pop_front();
        perm_r_in = r2;
        perm_c_in = c2;
        perm_done = 1'b1;
        g_fire = 1'b1;
        g_pending = 1'b0;
      end else begin
        g_cnt--;
      end
    end else if (perm_go && !reset) begin
      gos++;
      if (first_go_cyc < 0) first_go_cyc = cyc;
      if (gos <= exp_pr.size()) begin
        check("perm_r_at_go", perm_r, exp_pr[gos-1]);
        check("perm_c_at_go", perm_c, exp_pc[gos-1]);
        check("perm_rounds", perm_rounds, exp_rounds);
      end else begin
        check("extra_perm_go", 1'b1, 1'b0);
      end
      g_cap_r = perm_r; g_cap_c = perm_c; g_cap_rd = perm_rounds;
      g_cnt = (g_lat_fixed >= 0) ? g_lat_fixed : int'($urandom_range(0, 3));
      g_pending = 1'b1;
    end
  end

  // dout_ready driver: 0 = always ready, 1 = random, 2 = left to the test.
  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 0) dout_ready = 1'b1;
    else if (ready_mode == 1) dout_ready = 1'($urandom_range(0, 1));
  end

  // Spurious start (with junk length) and perm_done while the block is busy.
  bit spur_st = 1'b0;
  bit spur_pd = 1'b0;
  initial forever begin
    @(posedge clk);
    #2;
    if (spur_en && busy && !done) begin
      start = 1'($urandom_range(0, 1));
      out_len = 20'($urandom_range(0, 300));
      r_in = $urandom;
      spur_st = 1'b1;
    end else if (spur_st) begin
      start = 1'b0;
      spur_st = 1'b0;
    end
    if (spur_en && dout_valid && !g_pending && !spur_pd && ($urandom_range(0, 1) == 1)) begin
      perm_done = 1'b1;
      perm_r_in = $urandom;
      spur_pd = 1'b1;
    end else if (spur_pd) begin
      perm_done = 1'b0;
      spur_pd = 1'b0;
    end
  end

  task automatic run_body(input vec_t v);
    @(posedge clk);
    #1;
    r_in = v.r; c_in = v.c; out_len = v.len; rounds = v.rounds;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3000 && dones == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("done_count", dones, 1);
    check("beat_count", beats, exp_dout.size());
    check("perm_go_count", gos, exp_pr.size());
    if (v.len == 0) begin
      check("zero_done_lat", done_cyc, start_cyc + 1);
      check("zero_busy_cycles", busy_cnt, 1);
    end else begin
      check("first_valid_lat", first_valid_cyc, start_cyc + 1);
      check("done_after_last", done_cyc, last_hs_cyc + 1);
    end
  endtask

  task automatic run(input vec_t v);
    prep(v);
    run_body(v);
  endtask

  function automatic vec_t mk(input logic [31:0] r, input logic [319:0] c, input int len,
                              input int rd, input int rmode, input bit spur);
    vec_t v;
    v.r = r; v.c = c; v.len = 20'(len); v.rounds = 10'(rd); v.rmode = rmode; v.spur = spur;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    vec_t v;
    vecs[0] = mk(32'hDEADBEEF, {10{32'h01234567}}, 32, 3, 0, 0);
    vecs[1] = mk(32'hFFFFFFFF, {10{32'hA5A5A5A5}}, 1, 10, 0, 0);
    vecs[2] = mk(32'hFFFFFFFF, {10{32'h5A5A0F0F}}, 31, 7, 0, 0);
    vecs[3] = mk(32'hCAFEF00D, {10{32'h13572468}}, 33, 1, 0, 0);
    vecs[4] = mk(32'h12345678, {10{32'h0BADF00D}}, 64, 12, 1, 0);
    vecs[5] = mk(32'h87654321, {10{32'hFEEDFACE}}, 100, 5, 1, 1);
    vecs[6] = mk(32'h0F0F0F0F, {10{32'h11223344}}, 0, 2, 0, 0);
    vecs[7] = mk(32'h9ABCDEF0, {10{32'h55AA55AA}}, 97, 1023, 0, 1);

    // Reset: everything zero while asserted and after release.
    #3;
    check("reset_outs", {busy, perm_go, dout_valid, dout_last, done, dout_bits, dout, perm_r, perm_rounds}, '0);
    check("reset_perm_c", perm_c, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_outs", {busy, perm_go, dout_valid, dout_last, done, dout_bits, dout, perm_r, perm_rounds}, '0);

    foreach (vecs[i]) run(vecs[i]);

    // Multi-chunk with a scripted G.
    ovr_r = '{32'h11111111, 32'h2222ABCD};
    run(mk(32'hDEADBEEF, {10{32'h76543210}}, 80, 4, 0, 0));
    if (act_dout.size() == 3) begin
      check("mc_beat0", {act_dout[0], 6'(act_bits[0])}, {32'hDEADBEEF, 6'd32});
      check("mc_beat1", {act_dout[1], 6'(act_bits[1])}, {32'h11111111, 6'd32});
      check("mc_beat2", {act_dout[2], 6'(act_bits[2])}, {32'h0000ABCD, 6'd16});
    end else begin
      check("mc_beat_count", act_dout.size(), 3);
    end
    check("mc_perm_go", gos, 2);

    // Backpressure: five stalled cycles on the first beat.
    v = mk(32'h31415926, {10{32'h27182818}}, 64, 6, 2, 0);
    prep(v);
    dout_ready = 1'b0;
    fork
      run_body(v);
      begin
        for (int i = 0; i < 50 && first_valid_cyc < 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("stall_no_go", gos, 0);
        check("stall_no_beat", beats, 0);
        dout_ready = 1'b1;
      end
    join
    check("stall_len", first_hs_cyc - first_valid_cyc, 5);
    check("go_after_accept", first_go_cyc, first_hs_cyc + 1);

    // Reset while G is running, then a late perm_done.
    v = mk(32'h0C0FFEE0, {10{32'h99887766}}, 96, 8, 0, 0);
    prep(v);
    g_lat_fixed = 12;
    @(posedge clk);
    #1;
    r_in = v.r; c_in = v.c; out_len = v.len; rounds = v.rounds; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 200 && gos == 0; i++) @(posedge clk);
    check("rst_wait_go_seen", gos, 1);
    repeat (3) @(posedge clk);
    #1;
    stab_off = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_wait_outs", {busy, perm_go, dout_valid, dout_last, done, dout_bits, dout, perm_r, perm_rounds}, '0);
    check("rst_wait_perm_c", perm_c, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_counts();
    repeat (20) @(posedge clk);
    check("rst_late_done_busy", busy_cnt, 0);
    check("rst_late_done_valid", valid_cnt, 0);
    check("rst_late_done_pulse", dones, 0);
    check("rst_late_outs", {busy, perm_go, dout_valid, dout_last, done, dout_bits, dout, perm_r}, '0);
    stab_off = 1'b0;
    g_lat_fixed = -1;
    run(mk(32'h000000A5, {10{32'h0}}, 8, 1, 0, 0));
    if (act_dout.size() == 1)
      check("after_rst_beat", {act_dout[0], 6'(act_bits[0])}, {32'h000000A5, 6'd8});
    else
      check("after_rst_beat_count", act_dout.size(), 1);

    // Random runs, some with spurious inputs and random backpressure.
    for (int n = 0; n < 24; n++) begin
      run(mk($urandom, {$urandom, $urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom, $urandom},
             int'($urandom_range(0, 200)), int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
    end

    spur_en = 1'b0;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
